// File: rtl/sumres_pkg.sv
// Shared types and width helpers for the sumres_acc multi-operand add/sub accumulator.
package sumres_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } sumres_state_e;

    function automatic int sumres_out_w(input int w, input int n_ops);
        return w + $clog2(n_ops) + 1;
    endfunction

    function automatic int sumres_cnt_w(input int n_ops);
        return $clog2(n_ops + 1);
    endfunction

endpackage

// File: rtl/sumres_addsub.sv
// Combinational signed add/subtract of a zero-extended operand onto the running sum.
module sumres_addsub #(
    parameter int OUT_W = 7
) (
    input  logic signed [OUT_W-1:0] acc_i,
    input  logic        [OUT_W-1:0] a_ext_i,
    input  logic                    sub_i,
    output logic signed [OUT_W-1:0] sum_o
);

    // Result width leaves headroom for N_OPS full-scale operands, so no wrap.
    always_comb begin
        if (sub_i) begin
            sum_o = acc_i - $signed(a_ext_i);
        end else begin
            sum_o = acc_i + $signed(a_ext_i);
        end
    end

endmodule

// File: rtl/sumres_acc.sv
// Handshaked multi-operand add/subtract accumulator with registered signed result.
// Optional zero/neg result flags are enabled by defining SUMRES_FLAGS_EN.
module sumres_acc
    import sumres_pkg::*;
#(
    parameter  int W     = 4,
    parameter  int N_OPS = 3,
    localparam int OUT_W = sumres_out_w(W, N_OPS),
    localparam int CNT_W = sumres_cnt_w(N_OPS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            a,
    input  logic                    sub,
    input  logic                    last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] S,
    output logic [CNT_W-1:0]        n,
    output logic                    trunc
`ifdef SUMRES_FLAGS_EN
    ,
    output logic                    zero,
    output logic                    neg
`endif
);

    sumres_state_e           state_q, state_d;
    logic signed [OUT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [OUT_W-1:0] s_q, s_d;
    logic [CNT_W-1:0]        n_q, n_d;
    logic                    trunc_q, trunc_d;

    logic                    beat_acc_s;
    logic                    out_acc_s;
    logic                    close_s;
    logic signed [OUT_W-1:0] acc_base_s;
    logic [CNT_W-1:0]        cnt_inc_s;
    logic signed [OUT_W-1:0] sum_s;

    assign beat_acc_s = in_valid & in_ready;
    assign out_acc_s  = out_valid & out_ready;

    // A fresh frame starts from zero regardless of any stale accumulator contents.
    always_comb begin
        if (state_q == IDLE) begin
            acc_base_s = '0;
            cnt_inc_s  = CNT_W'(1);
        end else begin
            acc_base_s = acc_q;
            cnt_inc_s  = cnt_q + CNT_W'(1);
        end
        close_s = last | (cnt_inc_s == CNT_W'(N_OPS));
    end

    sumres_addsub #(
        .OUT_W (OUT_W)
    ) u_addsub (
        .acc_i   (acc_base_s),
        .a_ext_i ({{(OUT_W-W){1'b0}}, a}),
        .sub_i   (sub),
        .sum_o   (sum_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACC: begin
                if (beat_acc_s) begin
                    state_d = close_s ? HOLD : ACC;
                end else begin
                    state_d = state_q;
                end
            end
            HOLD: begin
                if (out_acc_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE, ACC: begin
                in_ready  = ~rst;
                out_valid = 1'b0;
            end
            HOLD: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Datapath next values: accumulate on each beat, capture the result on close.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        n_d     = n_q;
        trunc_d = trunc_q;
        if (beat_acc_s) begin
            if (close_s) begin
                acc_d   = '0;
                cnt_d   = '0;
                s_d     = sum_s;
                n_d     = cnt_inc_s;
                trunc_d = ~last;
            end else begin
                acc_d   = sum_s;
                cnt_d   = cnt_inc_s;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            s_q     <= '0;
            n_q     <= '0;
            trunc_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            n_q     <= n_d;
            trunc_q <= trunc_d;
        end
    end

    assign S     = s_q;
    assign n     = n_q;
    assign trunc = trunc_q;

`ifdef SUMRES_FLAGS_EN
    logic zero_q, neg_q;

    // Flags are captured alongside the result so they stay aligned with S.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (beat_acc_s && close_s) begin
            zero_q <= (sum_s == '0);
            neg_q  <= sum_s[OUT_W-1];
        end else begin
            zero_q <= zero_q;
            neg_q  <= neg_q;
        end
    end

    assign zero = zero_q;
    assign neg  = neg_q;
`endif

endmodule

// File: tb/tb_sumres_acc.sv
// Directed bench for sumres_acc with a frame-level reference model and per-cycle compare.
module tb_sumres_acc;

    localparam int W     = 4;
    localparam int N_OPS = 3;
    localparam int OUT_W = W + $clog2(N_OPS) + 1;
    localparam int CNT_W = $clog2(N_OPS + 1);

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [W-1:0]            a = '0;
    logic                    sub = 1'b0;
    logic                    last = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic signed [OUT_W-1:0] S;
    logic [CNT_W-1:0]        n;
    logic                    trunc;
`ifdef SUMRES_FLAGS_EN
    logic                    zero;
    logic                    neg;
`endif

    int tests = 0;
    int fails = 0;

    sumres_acc #(.W(W), .N_OPS(N_OPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .sub       (sub),
        .last      (last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .n         (n),
        .trunc     (trunc)
`ifdef SUMRES_FLAGS_EN
        ,
        .zero      (zero),
        .neg       (neg)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame-level integer arithmetic.
    bit m_hold;
    int m_sum, m_cnt, m_S, m_n;
    bit m_tr;

    function automatic int apply(input int base, input int av, input bit sb);
        return sb ? base - av : base + av;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hold <= 1'b0; m_sum <= 0; m_cnt <= 0;
            m_S <= 0; m_n <= 0; m_tr <= 1'b0;
        end else if (m_hold) begin
            if (out_ready) m_hold <= 1'b0;
        end else if (in_valid) begin
            if (last || (m_cnt + 1 == N_OPS)) begin
                m_hold <= 1'b1;
                m_S    <= apply(m_sum, int'(a), sub);
                m_n    <= m_cnt + 1;
                m_tr   <= !last;
                m_sum  <= 0;
                m_cnt  <= 0;
            end else begin
                m_sum <= apply(m_sum, int'(a), sub);
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // Compare process: every falling edge.
    always @(negedge clk) begin
        chk("in_ready", int'(in_ready), int'(!m_hold && !rst));
        chk("out_valid", int'(out_valid), int'(m_hold));
        if (m_hold) begin
            chk("S", int'(S), m_S);
            chk("n", int'(n), m_n);
            chk("trunc", int'(trunc), int'(m_tr));
`ifdef SUMRES_FLAGS_EN
            chk("zero", int'(zero), int'(m_S == 0));
            chk("neg", int'(neg), int'(m_S < 0));
`endif
        end
    end

    task automatic beat(input int av, input bit sb, input bit lst);
        in_valid = 1'b1; a = W'(av); sub = sb; last = lst;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #2;
                in_valid = 1'b0;
                return;
            end
        end
        chk("beat_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic take(input int hold, input int eS, input int en, input bit etr);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk("result_timeout", int'(seen), 1);
        chk("lit_S", int'(S), eS);
        chk("lit_n", int'(n), en);
        chk("lit_trunc", int'(trunc), int'(etr));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_S", int'(S), eS);
            chk("hold_ready", int'(in_ready), 0);
        end
        @(posedge clk); #2;
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
        chk("post_take_valid", int'(out_valid), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #23 rst = 1'b0;
        @(negedge clk);
        chk("rst_S", int'(S), 0);
        chk("rst_n", int'(n), 0);
        chk("rst_ready", int'(in_ready), 1);
        @(posedge clk); #2;

        // 1: 3+4+5
        beat(3, 0, 0); beat(4, 0, 0); beat(5, 0, 1);
        take(0, 12, 3, 0);
        // 2: 9-1-2, then single beat
        beat(9, 0, 0); beat(1, 1, 0); beat(2, 1, 1);
        take(0, 6, 3, 0);
        beat(7, 0, 1);
        take(0, 7, 1, 0);
        // 3: -45, then zero
        beat(15, 1, 0); beat(15, 1, 0); beat(15, 1, 1);
        take(0, -45, 3, 0);
`ifdef SUMRES_FLAGS_EN
        chk("lit_neg_prev", int'(neg), 1);
`endif
        beat(5, 0, 0); beat(5, 1, 1);
        take(0, 0, 2, 0);
`ifdef SUMRES_FLAGS_EN
        chk("lit_zero_prev", int'(zero), 1);
`endif
        // 4: forced close, 4th beat held off until result taken
        beat(1, 0, 0); beat(2, 0, 0); beat(3, 0, 0);
        in_valid = 1'b1; a = W'(9); sub = 1'b0; last = 1'b1;
        take(3, 6, 3, 1);
        @(posedge clk); #2;
        in_valid = 1'b0;
        take(0, 9, 1, 0);
        // last on the N_OPS-th operand is not a truncation
        beat(2, 0, 0); beat(2, 0, 0); beat(2, 0, 1);
        take(0, 6, 3, 0);
        // 5: long hold
        beat(8, 0, 0); beat(3, 1, 1);
        take(5, 5, 2, 0);
        chk("rel_ready", int'(in_ready), 1);
        // 6: async reset mid-frame
        beat(4, 0, 0); beat(6, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_ready", int'(in_ready), 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk("arst_no_result", int'(out_valid), 0);
        @(posedge clk); #2;
        beat(7, 0, 1);
        take(0, 7, 1, 0);
        repeat (3) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sumres_acc.md
Name: sumres_acc

Overview:
Parametrised, handshaked multi-operand add/subtract accumulator. It generalises the fixed 3-operand, 4-bit add/sub unit to W-bit operands and frames of up to N_OPS operands, each operand carrying its own add/subtract flag. Operands stream in one per cycle on a valid/ready input. A full-precision signed result with an operand count is presented on a valid/ready output. It sits between an operand source (register file or sequencer) and any result consumer in the arithmetic test datapath.

Parameters:
W, 4, operand width in bits (unsigned operands), W >= 2
N_OPS, 3, maximum operands per frame, N_OPS >= 1
(derived localparam) OUT_W = W + $clog2(N_OPS) + 1, signed result width, never overflows
(derived localparam) CNT_W = $clog2(N_OPS+1), operand-count width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat
a  in  W  unsigned operand
sub  in  1  1 = subtract this operand, 0 = add (first operand included)
last  in  1  final operand of the frame
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
S  out  OUT_W  signed two's-complement frame result
n  out  CNT_W  number of operands accumulated in the frame
trunc  out  1  frame force-closed at N_OPS without last

Behaviour:
- Reset (asynchronous on rst rising, held while rst=1): state=IDLE, acc=0, cnt=0, out_valid=0, S=0, n=0, trunc=0, in_ready=1 once rst is low.
- Beat accept = in_valid & in_ready. Output accept = out_valid & out_ready.
- FSM states: IDLE, ACC, HOLD.
- IDLE: in_ready=1. On accept: acc <= sub ? -zext(a) : zext(a), cnt <= 1. Go to HOLD if last or N_OPS==1, otherwise go to ACC.
- ACC: in_ready=1. On accept: acc <= acc ± zext(a), cnt <= cnt+1. Go to HOLD if last or cnt+1==N_OPS. No accept: stay, acc unchanged (gaps allowed).
- HOLD: in_ready=0, out_valid=1. S, n and trunc are registered and stable until output accept. On output accept go to IDLE, out_valid=0.
- Latency: out_valid rises on the cycle after the closing beat is accepted. Minimum gap between frames is one cycle; no in/out overlap in HOLD.
- trunc=1 only when the frame closed because cnt reached N_OPS while last=0. A beat with last=1 on the N_OPS-th operand gives trunc=0.
- All arithmetic is sign-extended to OUT_W, so there is no wrap. Range is ±N_OPS*(2^W-1).
- in_valid is ignored when in_ready=0. a, sub and last are sampled only on accept.
- rst asserted mid-frame or in HOLD: the partial frame is discarded and no result is emitted.

Optional Feature:
SUMRES_FLAGS_EN defined:
- adds output ports zero (1 bit, S==0) and neg (1 bit, S[OUT_W-1]);
- both are registered with S, reset to 0, and stable in HOLD.
SUMRES_FLAGS_EN undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package sumres_pkg holds:
  - state enum (IDLE, ACC, HOLD);
  - function sumres_out_w(W, N_OPS) returning OUT_W;
  - function sumres_cnt_w(N_OPS) returning CNT_W.
- One sub-module, sumres_addsub: combinational OUT_W adder that takes acc, zero-extended a and sub, and returns acc ± a. It is instanced once inside sumres_acc.

Test Plan:
1. (W=4, N_OPS=3, all cases) Reset, then beats a=3,4,5 with sub=0 and last on the 3rd -> one cycle later out_valid=1, S=12, n=3, trunc=0.
2. Beats 9(add), 1(sub), 2(sub) with last on the 3rd -> S=6, n=3. Then a single beat a=7, last=1 from IDLE -> S=7, n=1.
3. Beats 15,15,15, all sub=1, last on the 3rd -> S=-45 (7'b1010011), n=3. With SUMRES_FLAGS_EN: neg=1, zero=0. Beats 5(add), 5(sub), last -> S=0, zero=1.
4. Beats 1,2,3 with last=0 throughout -> forced close, S=6, n=3, trunc=1. The 4th in_valid is held off (in_ready=0) until the result is taken.
5. Hold out_ready=0 for 5 cycles in HOLD -> S, n, out_valid stable and in_ready=0. Release out_ready -> out_valid falls next cycle and in_ready=1.
6. Assert rst asynchronously after 2 accepted beats -> out_valid=0 immediately, no result. After release, beat a=7 with last -> S=7, n=1.
